// File: rtl/diff_freq_serial_in.sv
// diff_freq_serial_in
// Receives one serial word whose bit periods vary bit-by-bit according to a
// latched frequency pattern (1 = FAST_TICKS, 0 = SLOW_TICKS clocks per bit).
// The captured word is then streamed out least-significant byte first
// through a UART-transmitter style start/done handshake.
//
// Optional build macro: DIFF_FREQ_SERIAL_IN_PARITY_BYTE_EN
//   When defined, one extra byte is sent after the data bytes. It holds
//   the XOR of all data bytes. When undefined, only data bytes are sent.

module diff_freq_serial_in #(
    parameter int DATA_BIT   = 32,
    parameter int FAST_TICKS = 10,
    parameter int SLOW_TICKS = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_serial_in,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic                i_start,
    input  logic                i_tx_done_tick,
    output logic                o_tx_start,
    output logic [7:0]          o_tx_data,
    output logic                o_bit_tick,
    output logic                o_done_tick,
    output logic                o_busy
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int NUM_DATA_BYTES = DATA_BIT / 8;
`ifdef DIFF_FREQ_SERIAL_IN_PARITY_BYTE_EN
    localparam int NUM_BYTES      = NUM_DATA_BYTES + 1;
`else
    localparam int NUM_BYTES      = NUM_DATA_BYTES;
`endif
    localparam int MAX_TICKS = (FAST_TICKS > SLOW_TICKS) ? FAST_TICKS : SLOW_TICKS;
    localparam int TICK_W    = $clog2(MAX_TICKS);
    localparam int IDX_W     = $clog2(DATA_BIT);
    localparam int BIT_W     = IDX_W + 1;
    localparam int BYTE_W    = $clog2(NUM_BYTES + 1);

    localparam logic [TICK_W-1:0] FAST_LAST = TICK_W'(FAST_TICKS - 1);
    localparam logic [TICK_W-1:0] SLOW_LAST = TICK_W'(SLOW_TICKS - 1);
    localparam logic [TICK_W-1:0] FAST_HALF = TICK_W'(FAST_TICKS / 2);
    localparam logic [TICK_W-1:0] SLOW_HALF = TICK_W'(SLOW_TICKS / 2);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BIT - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

    // Parameter sanity: the byte stream and the mid-bit sample point need
    // these to hold (sample must land after the 2-cycle synchronizer delay).
    if ((DATA_BIT % 8) != 0 || DATA_BIT < 8) begin : g_bad_data_bit
        $error("DATA_BIT must be a multiple of 8 and at least 8");
    end
    if (FAST_TICKS < 6 || SLOW_TICKS < 6) begin : g_bad_ticks
        $error("FAST_TICKS and SLOW_TICKS must be at least 6");
    end

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        LOAD,
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t              state;
    logic                sync_1;
    logic                sync_2;
    logic [DATA_BIT-1:0] pattern;
    logic [DATA_BIT-1:0] shift;
    logic [TICK_W-1:0]   tick_cnt;
    logic [BIT_W-1:0]    bit_idx;
    logic [BYTE_W-1:0]   byte_idx;

    logic                cur_fast;
    logic [TICK_W-1:0]   tick_last;
    logic [TICK_W-1:0]   tick_half;
    logic [7:0]          tx_byte;

    // Two-flop synchronizer for the asynchronous serial line.
    // NOTE: sequential state uses non-blocking assignments so sync_2 takes
    // the old sync_1, giving a true two-stage delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= i_serial_in;
            sync_2 <= sync_1;
        end
    end

    // Bit period and mid-bit sample point for the bit being captured.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cur_fast  = pattern[bit_idx[IDX_W-1:0]];
        tick_last = SLOW_LAST;
        tick_half = SLOW_HALF;
        if (cur_fast) begin
            tick_last = FAST_LAST;
            tick_half = FAST_HALF;
        end
    end

`ifdef DIFF_FREQ_SERIAL_IN_PARITY_BYTE_EN
    logic [7:0] parity_byte;

    // XOR of all captured data bytes, sent as the trailing byte.
    always_comb begin
        parity_byte = '0;
        for (int b = 0; b < NUM_DATA_BYTES; b++) begin
            parity_byte = parity_byte ^ shift[8*b +: 8];
        end
    end
`endif

    // Select the byte addressed by byte_idx, least-significant byte first.
    always_comb begin
        tx_byte = '0;
        for (int b = 0; b < NUM_DATA_BYTES; b++) begin
            if (byte_idx == BYTE_W'(b)) begin
                tx_byte = shift[8*b +: 8];
            end
        end
`ifdef DIFF_FREQ_SERIAL_IN_PARITY_BYTE_EN
        if (byte_idx == BYTE_W'(NUM_DATA_BYTES)) begin
            tx_byte = parity_byte;
        end
`endif
    end

    // Main control FSM: capture bits at their own periods, then stream bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pattern     <= '0;
            shift       <= '0;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            o_tx_start  <= 1'b0;
            o_tx_data   <= '0;
            o_bit_tick  <= 1'b0;
            o_done_tick <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_tx_start  <= 1'b0;
            o_bit_tick  <= 1'b0;
            o_done_tick <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        pattern  <= i_freq_pattern;
                        shift    <= '0;
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        o_busy   <= 1'b1;
                        state    <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (tick_cnt == tick_half) begin
                        shift[bit_idx[IDX_W-1:0]] <= sync_2;
                    end
                    if (tick_cnt == tick_last) begin
                        o_bit_tick <= 1'b1;
                        tick_cnt   <= '0;
                        bit_idx    <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            byte_idx <= '0;
                            state    <= LOAD;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                // o_tx_start is registered here so it is high during SEND,
                // the same cycle o_tx_data first shows the new byte.
                LOAD: begin
                    o_tx_data  <= tx_byte;
                    o_tx_start <= 1'b1;
                    state      <= SEND;
                end

                SEND: begin
                    state <= WAIT;
                end

                WAIT: begin
                    if (i_tx_done_tick) begin
                        if (byte_idx == LAST_BYTE) begin
                            o_done_tick <= 1'b1;
                            state       <= DONE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= LOAD;
                        end
                    end
                end

                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
